// File: rtl/ram_pkg.sv
// Shared encodings for the RAM responder and the control unit that drives it.
package ram_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Reserved size 2'b11 is handled as a word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        if (size == SIZE_BYTE) return 1'b0;
        if (size == SIZE_HALF) return lo[0];
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// MOV/RW/MOC memory handshake bundle between the initiator (master) and the responder (slave).
// Handshake: master raises MOV with stable RW/Size/SE/Address/DataIn and holds it until MOC is seen; slave raises MOC (with DataOut/ERR valid) and holds it until MOV drops; MOV must then be low for at least one edge before the next request.
interface ram_responder_if #(
    parameter int ADDR_W = 9
);
    logic              MOV;
    logic              RW;
    logic [1:0]        Size;
    logic              SE;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              MOC;
    logic              ERR;

    modport master (
        output MOV, RW, Size, SE, Address, DataIn,
        input  DataOut, MOC, ERR
    );

    modport slave (
        input  MOV, RW, Size, SE, Address, DataIn,
        output DataOut, MOC, ERR
    );
endinterface

// File: rtl/ram_lane_align.sv
// Combinational byte-lane steering: write enables/data per lane and the extended read word.
// Lane i is the byte at word base + i, carried in bits [31-8i -: 8] (big-endian).
module ram_lane_align
    import ram_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        se,
    input  logic [31:0] din,
    input  logic [31:0] rbytes,
    output logic [3:0]  be,
    output logic [31:0] wbytes,
    output logic [31:0] rdata
);
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        be     = 4'b1111;
        wbytes = din;
        rdata  = rbytes;
        sel_h  = lo[1] ? rbytes[15:0] : rbytes[31:16];
        case (lo)
            2'd0:    sel_b = rbytes[31:24];
            2'd1:    sel_b = rbytes[23:16];
            2'd2:    sel_b = rbytes[15:8];
            default: sel_b = rbytes[7:0];
        endcase

        // Halfword lane choice ignores lo[0], which is what forces alignment.
        case (size)
            SIZE_BYTE: begin
                be     = 4'b0001 << lo;
                wbytes = {4{din[7:0]}};
                rdata  = {{24{se & sel_b[7]}}, sel_b};
            end
            SIZE_HALF: begin
                be     = lo[1] ? 4'b1100 : 4'b0011;
                wbytes = {2{din[15:0]}};
                rdata  = {{16{se & sel_h[15]}}, sel_h};
            end
            default: begin
                be     = 4'b1111;
                wbytes = din;
                rdata  = rbytes;
            end
        endcase
    end
endmodule

// File: rtl/ram_responder.sv
// Memory-side MOV/RW/MOC responder with programmable latency over a big-endian byte array Mem.
// Define MISALIGN_TRAP_EN to report misaligned halfword/word accesses on ERR instead of aligning them.
module ram_responder
    import ram_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic           Clk,
    input  logic           Clr,
    ram_responder_if.slave bus,
    output state_t         dbg_state
);
    logic [7:0] Mem [0:(2**ADDR_W)-1];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              moc_q, moc_d;
    logic              err_q, err_d;
    logic [31:0]       dout_q;
    logic              rw_q, se_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic              accept, commit, trap;
    logic [ADDR_W-3:0] wbase;
    logic [3:0]        be;
    logic [31:0]       wbytes, rbytes, rdata;

    assign wbase  = addr_q[ADDR_W-1:2];
    assign rbytes = {Mem[{wbase, 2'd0}], Mem[{wbase, 2'd1}], Mem[{wbase, 2'd2}], Mem[{wbase, 2'd3}]};

`ifdef MISALIGN_TRAP_EN
    assign trap = misaligned(size_q, addr_q[1:0]);
`else
    assign trap = 1'b0;
`endif

    ram_lane_align u_align (
        .size   (size_q),
        .lo     (addr_q[1:0]),
        .se     (se_q),
        .din    (din_q),
        .rbytes (rbytes),
        .be     (be),
        .wbytes (wbytes),
        .rdata  (rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        moc_d   = moc_q;
        err_d   = err_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (bus.MOV) begin
                accept  = 1'b1;
                cnt_d   = 4'(LATENCY - 1);
                state_d = BUSY;
            end
            BUSY: begin
                // A dropped MOV abandons the access before anything is committed.
                if (!bus.MOV) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    moc_d   = 1'b1;
                    err_d   = trap;
                    state_d = DONE;
                end
            end
            DONE: if (!bus.MOV) begin
                moc_d   = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'd0;
            rw_q    <= RW_READ;
            se_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            din_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            if (accept) begin
                rw_q   <= bus.RW;
                se_q   <= bus.SE;
                size_q <= bus.Size;
                addr_q <= bus.Address;
                din_q  <= bus.DataIn;
            end
            if (commit && rw_q == RW_READ && !trap) dout_q <= rdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (commit && rw_q == RW_WRITE && !trap) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) Mem[{wbase, 2'(i)}] <= wbytes[8*(3-i) +: 8];
            end
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.MOC     = moc_q;
    assign bus.ERR     = err_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder (LATENCY=3): byte-array model feeding an expected queue, plus handshake/abort/reset directed cases.
module tb_ram_responder;
    import ram_pkg::*;

    localparam int ADDR_W = 9;
    localparam int LAT    = 3;

    logic   Clk;
    logic   Clr;
    state_t dbg_state;

    ram_responder_if #(.ADDR_W(ADDR_W)) bus ();

    ram_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  model_mem [0:(2**ADDR_W)-1];
    logic [31:0] last_dout = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {ERR, DataOut} for one access; updates the model array on writes.
    task automatic model_access(input logic rw, input logic [1:0] size, input logic se,
                                input int addr, input logic [31:0] din);
        int          a;
        logic        bad;
        logic [31:0] v;
        bad = 1'b0;
        v   = 32'd0;
`ifdef MISALIGN_TRAP_EN
        if (size == SIZE_HALF) bad = (addr % 2) != 0;
        else if (size != SIZE_BYTE) bad = (addr % 4) != 0;
`endif
        case (size)
            SIZE_BYTE: a = addr;
            SIZE_HALF: a = addr - (addr % 2);
            default:   a = addr - (addr % 4);
        endcase
        if (!bad) begin
            if (rw == RW_WRITE) begin
                case (size)
                    SIZE_BYTE: model_mem[a] = din[7:0];
                    SIZE_HALF: begin
                        model_mem[a]   = din[15:8];
                        model_mem[a+1] = din[7:0];
                    end
                    default: begin
                        model_mem[a]   = din[31:24];
                        model_mem[a+1] = din[23:16];
                        model_mem[a+2] = din[15:8];
                        model_mem[a+3] = din[7:0];
                    end
                endcase
            end else begin
                case (size)
                    SIZE_BYTE: v = {{24{se & model_mem[a][7]}}, model_mem[a]};
                    SIZE_HALF: v = {{16{se & model_mem[a][7]}}, model_mem[a], model_mem[a+1]};
                    default:   v = {model_mem[a], model_mem[a+1], model_mem[a+2], model_mem[a+3]};
                endcase
                last_dout = v;
            end
        end
        exp_q.push_back({bad, last_dout});
    endtask

    task automatic do_access(input logic rw, input logic [1:0] size, input logic se,
                             input int addr, input logic [31:0] din, output logic [31:0] got);
        int          edges;
        logic [32:0] e;
        logic [31:0] held;
        @(negedge Clk);
        bus.MOV     = 1'b1;
        bus.RW      = rw;
        bus.Size    = size;
        bus.SE      = se;
        bus.Address = ADDR_W'(addr);
        bus.DataIn  = din;
        model_access(rw, size, se, addr, din);
        edges = -1;
        do begin
            @(posedge Clk);
            #1;
            edges++;
        end while (!bus.MOC && edges < 20);
        check("moc_latency", 32'(edges), 32'(LAT));
        e   = exp_q.pop_front();
        got = bus.DataOut;
        check("dout", bus.DataOut, e[31:0]);
        check("err", 32'(bus.ERR), 32'(e[32]));
        held = bus.DataOut;
        repeat (2) begin
            @(posedge Clk);
            #1;
            check("moc_hold", 32'(bus.MOC), 32'd1);
            check("dout_hold", bus.DataOut, held);
        end
        @(negedge Clk);
        bus.MOV = 1'b0;
        @(posedge Clk);
        #1;
        check("moc_fall", 32'(bus.MOC), 32'd0);
        check("err_fall", 32'(bus.ERR), 32'd0);
        check("idle_after", 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        logic [31:0] got;
        Clr         = 1'b0;
        bus.MOV     = 1'b0;
        bus.RW      = RW_READ;
        bus.Size    = SIZE_BYTE;
        bus.SE      = 1'b0;
        bus.Address = '0;
        bus.DataIn  = 32'd0;
        repeat (3) @(negedge Clk);
        check("rst_moc", 32'(bus.MOC), 32'd0);
        check("rst_dout", bus.DataOut, 32'd0);
        check("rst_err", 32'(bus.ERR), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        Clr = 1'b1;

        do_access(RW_WRITE, SIZE_WORD, 1'b0, 8, 32'hDEADBEEF, got);
        do_access(RW_READ, SIZE_WORD, 1'b0, 8, 32'h0, got);
        check("word_rd", got, 32'hDEADBEEF);
        check("mem8", 32'(dut.Mem[8]), 32'h0000_00DE);
        check("mem11", 32'(dut.Mem[11]), 32'h0000_00EF);

        do_access(RW_WRITE, SIZE_HALF, 1'b0, 10, 32'h0000_1234, got);
        do_access(RW_READ, SIZE_WORD, 1'b0, 8, 32'h0, got);
        check("half_merge", got, 32'hDEAD1234);

        do_access(RW_WRITE, SIZE_BYTE, 1'b0, 9, 32'h0000_0085, got);
        do_access(RW_READ, SIZE_BYTE, 1'b1, 9, 32'h0, got);
        check("byte_sext", got, 32'hFFFFFF85);
        do_access(RW_READ, SIZE_BYTE, 1'b0, 9, 32'h0, got);
        check("byte_zext", got, 32'h00000085);
        do_access(RW_READ, SIZE_HALF, 1'b1, 8, 32'h0, got);
        check("half_sext", got, 32'hFFFFDE85);
        do_access(RW_READ, SIZE_HALF, 1'b0, 10, 32'h0, got);
        check("half_zext", got, 32'h00001234);

        do_access(RW_WRITE, SIZE_WORD, 1'b0, 4, 32'h11223344, got);
        do_access(RW_WRITE, SIZE_WORD, 1'b0, 5, 32'hCAFEF00D, got);
        do_access(RW_READ, SIZE_WORD, 1'b0, 4, 32'h0, got);
`ifdef MISALIGN_TRAP_EN
        check("misalign_word", got, 32'h11223344);
        check("misalign_mem4", 32'(dut.Mem[4]), 32'h0000_0011);
`else
        check("misalign_word", got, 32'hCAFEF00D);
        check("misalign_mem4", 32'(dut.Mem[4]), 32'h0000_00CA);
`endif

        // Abort: MOV dropped one edge after accept, write must not land.
        @(negedge Clk);
        bus.MOV     = 1'b1;
        bus.RW      = RW_WRITE;
        bus.Size    = SIZE_WORD;
        bus.Address = ADDR_W'(8);
        bus.DataIn  = 32'h0BADF00D;
        @(posedge Clk);
        @(negedge Clk);
        bus.MOV = 1'b0;
        repeat (5) begin
            @(posedge Clk);
            #1;
            check("abort_moc", 32'(bus.MOC), 32'd0);
        end
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        check("abort_dout", bus.DataOut, last_dout);
        for (int i = 8; i < 12; i++) check("abort_mem", 32'(dut.Mem[i]), 32'(model_mem[i]));

        // Reset in BUSY: outputs clear at once and the pending write is discarded.
        @(negedge Clk);
        bus.MOV    = 1'b1;
        bus.DataIn = 32'h55AA55AA;
        @(posedge Clk);
        #3;
        Clr = 1'b0;
        #1;
        check("clr_moc", 32'(bus.MOC), 32'd0);
        check("clr_dout", bus.DataOut, 32'd0);
        check("clr_state", 32'(dbg_state), 32'(IDLE));
        bus.MOV   = 1'b0;
        last_dout = 32'd0;
        @(negedge Clk);
        Clr = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        for (int i = 8; i < 12; i++) check("clr_mem", 32'(dut.Mem[i]), 32'(model_mem[i]));

        for (int w = 0; w < 8; w++) do_access(RW_WRITE, SIZE_WORD, 1'b0, 32 + 4 * w, $urandom, got);
        for (int n = 0; n < 24; n++) begin
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom_range(32, 63), $urandom, got);
        end
        for (int i = 32; i < 64; i++) check("final_mem", 32'(dut.Mem[i]), 32'(model_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the control unit's MOV/RW/MOC handshake.
- Accepts a request (MOV high), waits a programmable latency, performs a byte/halfword/word access on an internal byte-addressed big-endian array, then raises MOC.
- MOC stays high until the initiator drops MOV.
- Sits between the datapath (MAR/MDR) and the control unit's MOC input.

Parameters:
- ADDR_W, 9, address width in bits; array depth is 2**ADDR_W bytes.
- LATENCY, 2, clock edges from request accept to access commit; legal range 1..15.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Clr  in  1  asynchronous, active-low reset.
- MOV  in  1  memory operation valid; held high by the initiator until MOC is seen.
- RW  in  1  1 = read, 0 = write.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- SE  in  1  reads only: 1 = sign-extend byte/halfword, 0 = zero-extend.
- Address  in  ADDR_W  byte address.
- DataIn  in  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
- DataOut  out  32  read data, right-justified and extended per SE.
- MOC  out  1  memory operation complete.
- ERR  out  1  misaligned-access flag; tied 0 unless MISALIGN_TRAP_EN is defined.

Behaviour:
- Reset (Clr low, asynchronous):
  - State goes to IDLE; MOC=0, DataOut=0, ERR=0, latency counter=0.
  - Array contents are not reset. The array is named Mem, so a bench can preload it hierarchically.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On an edge with MOV=1, latch RW, Size, SE, Address and DataIn; load counter with LATENCY-1; go to BUSY.
  - Inputs are not sampled again until the next accept.
- BUSY:
  - Counter != 0: decrement.
  - Counter == 0: commit the access and go to DONE. MOC=1 is registered on the same edge.
  - If MOV is accepted at edge k, MOC is visible after edge k+LATENCY.
- BUSY abort: if MOV is sampled low in BUSY, go to IDLE with no write, DataOut unchanged and MOC stays 0.
- DONE:
  - MOC held at 1 and DataOut held stable.
  - On an edge with MOV=0: MOC=0, go to IDLE.
  - Back-to-back requests therefore need MOV low for at least one edge.
- Addressing (big-endian):
  - Word at A occupies Mem[A]..Mem[A+3], with Mem[A] in DataOut[31:24].
  - Halfword at A: Mem[A] in bits [15:8], Mem[A+1] in bits [7:0].
- Writes modify only the addressed bytes; neighbouring bytes are preserved.
- Reads update DataOut only at the commit edge.
  - Byte and halfword reads fill the upper bits with zeros or the sign bit, per SE.
  - Writes leave DataOut unchanged.
- Alignment without macro: low address bits are forced aligned. Halfword clears bit 0; word clears bits [1:0]. ERR stays 0.
- Address wrap: the address is exactly ADDR_W bits; no out-of-range condition exists.
- Reset mid-operation: any access not yet committed is discarded; a write committed at an earlier edge remains in Mem.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A halfword with Address[0]=1, or a word with Address[1:0]!=0, is misaligned.
  - At the commit edge a misaligned access writes nothing and leaves DataOut unchanged.
  - ERR=1 and MOC=1 together; ERR clears with MOC.
- Undefined: the alignment-forcing behaviour above applies and ERR is constant 0.

Decomposition:
- Shared package ram_pkg holds:
  - SIZE_BYTE / SIZE_HALF / SIZE_WORD encodings;
  - the 2-bit FSM state encodings IDLE=00, BUSY=01, DONE=10;
  - the RW_READ=1 / RW_WRITE=0 constants (also used by the control unit microstore).
- One sub-module, ram_lane_align (combinational):
  - maps Size, address low bits and SE to per-byte write enables;
  - builds the extended read word from the four fetched bytes.

Test Plan:
- Word write then read: write 32'hDEADBEEF at Address 8, then read word at 8 → DataOut=32'hDEADBEEF. Mem[8]=8'hDE and Mem[11]=8'hEF.
- Byte read extension: with Mem[9]=8'h85, read byte at 9 with SE=1 → 32'hFFFFFF85; with SE=0 → 32'h00000085.
- Halfword write preserves neighbours: after the word at 8 holds DEADBEEF, write halfword 16'h1234 at 10. A word read at 8 → 32'hDEAD1234.
- Latency and handshake, LATENCY=3:
  - MOV accepted at edge k → MOC rises after edge k+3.
  - MOC stays high while MOV is held; MOC falls the edge after MOV drops.
- Abort and reset:
  - MOV dropped during BUSY on a write → Mem unchanged, MOC never asserts.
  - Clr pulsed low during BUSY → MOC=0 and DataOut=0 immediately, state IDLE.
- Misalignment:
  - With MISALIGN_TRAP_EN, a word write at Address 5 → ERR=1 with MOC=1, Mem unchanged.
  - Without the macro, the same write lands at Address 4 and ERR=0.
